// File: rtl/ann_dqn_sequencer.sv
// DQN top-level sequencer: serialises state samples into main/target nets,
// arbitrates the shared weight port and reports the chosen action.
module ann_dqn_sequencer #(
   parameter int DATA_WIDTH                    = 32,
   parameter int ACTION_WIDTH                  = 2,
   parameter int LAYER_WIDTH                   = 2,
   parameter int WEIGHT_COUNTER_WIDTH          = 11,
   parameter int NUMBER_OF_INPUT_NODE          = 2,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
   parameter int NUMBER_OF_OUTPUT_NODE         = 3,
   localparam int DW  = DATA_WIDTH,
   localparam int AW  = ACTION_WIDTH,
   localparam int LW  = LAYER_WIDTH,
   localparam int WCW = WEIGHT_COUNTER_WIDTH,
   localparam int N   = NUMBER_OF_INPUT_NODE,
   localparam int DCW = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [N*DW-1:0] i_current_state,
   input  logic [N*DW-1:0] i_next_state,
   output logic           o_data_valid,
   output logic [DCW-1:0] o_data_addr,
   output logic [DW-1:0]  o_main_data,
   output logic [DW-1:0]  o_target_data,
   input  logic           i_weight_valid,
   input  logic [LW-1:0]  i_weight_layer,
   input  logic [WCW-1:0] i_weight_addr,
   input  logic [DW-1:0]  i_weight,
   input  logic           i_update_request,
   output logic           o_update_start,
   input  logic           i_soft_rd_valid,
   input  logic [LW-1:0]  i_soft_rd_layer,
   input  logic [WCW-1:0] i_soft_rd_addr,
   input  logic           i_soft_wr_valid,
   input  logic [LW-1:0]  i_soft_wr_layer,
   input  logic [WCW-1:0] i_soft_wr_addr,
   input  logic [DW-1:0]  i_soft_wr_data,
   input  logic           i_soft_done,
   output logic           o_weight_valid,
   output logic           o_rw_weight_select,
   output logic [LW-1:0]  o_weight_layer,
   output logic [WCW-1:0] o_weight_addr,
   output logic [DW-1:0]  o_weight,
   input  logic           i_arg_max_valid,
   input  logic [AW-1:0]  i_arg_max,
   input  logic           i_main_net_done,
   output logic [AW-1:0]  o_action,
   output logic           o_action_valid,
   output logic           o_busy
);

   localparam int LAST_W = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1) - 1;
   localparam logic [WCW-1:0] LAST_ADDR = WCW'(LAST_W);
   localparam logic [DCW-1:0] LAST_IDX  = DCW'(N - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_FEED,
      S_WAIT,
      S_UPD_RD,
      S_UPD_WR
   } state_t;

   state_t state, state_next;

   logic [N*DW-1:0] cur_q, nxt_q;
   logic [DCW-1:0]  idx;
   logic            upd_pend;
   logic [AW-1:0]   arg_q;

   logic            hs, start, fwd, fwd_read;
   logic [LW-1:0]   fwd_layer;
   logic [WCW-1:0]  fwd_addr;
   logic [DW-1:0]   fwd_data;
   logic [DW-1:0]   main_word, target_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      hs         = 1'b0;
      start      = 1'b0;
      fwd        = 1'b0;
      fwd_read   = 1'b0;
      fwd_layer  = i_weight_layer;
      fwd_addr   = i_weight_addr;
      fwd_data   = i_weight;
      case (state)
         S_INIT: begin
            fwd = i_weight_valid;
            if (i_weight_valid && i_weight_layer == '1 && i_weight_addr == LAST_ADDR)
               state_next = S_IDLE;
         end
         S_IDLE: begin
            if (upd_pend) begin
               start      = 1'b1;
               state_next = S_UPD_RD;
            end else if (i_valid) begin
               hs         = 1'b1;
               state_next = S_FEED;
            end
         end
         S_FEED: if (idx == LAST_IDX) state_next = S_WAIT;
         S_WAIT: if (i_main_net_done) state_next = S_IDLE;
         S_UPD_RD: begin
            // reads carry no data; keep the last write value on the port
            fwd       = i_soft_rd_valid;
            fwd_read  = 1'b1;
            fwd_layer = i_soft_rd_layer;
            fwd_addr  = i_soft_rd_addr;
            fwd_data  = o_weight;
            if (i_soft_rd_valid && i_soft_rd_layer == '1 && i_soft_rd_addr == LAST_ADDR)
               state_next = S_UPD_WR;
         end
         S_UPD_WR: begin
            fwd       = i_soft_wr_valid;
            fwd_layer = i_soft_wr_layer;
            fwd_addr  = i_soft_wr_addr;
            fwd_data  = i_soft_wr_data;
            if (i_soft_done) state_next = S_IDLE;
         end
         default: state_next = S_INIT;
      endcase
   end

   always_comb begin
      main_word   = '0;
      target_word = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (idx == DCW'(k)) begin
            main_word   = cur_q[k*DW +: DW];
            target_word = nxt_q[k*DW +: DW];
         end
      end
   end

   assign o_ready       = (state == S_IDLE) && !upd_pend;
   assign o_data_valid  = (state == S_FEED);
   assign o_data_addr   = (state == S_FEED) ? idx : '0;
   assign o_main_data   = (state == S_FEED) ? main_word : '0;
   assign o_target_data = (state == S_FEED) ? target_word : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q              <= '0;
         nxt_q              <= '0;
         idx                <= '0;
         upd_pend           <= 1'b0;
         o_update_start     <= 1'b0;
         o_weight_valid     <= 1'b0;
         o_rw_weight_select <= 1'b0;
         o_weight_layer     <= '0;
         o_weight_addr      <= '0;
         o_weight           <= '0;
         arg_q              <= '0;
         o_action           <= '0;
         o_action_valid     <= 1'b0;
         o_busy             <= 1'b0;
      end else begin
         if (hs) begin
            cur_q <= i_current_state;
            nxt_q <= i_next_state;
            idx   <= '0;
         end else if (state == S_FEED && idx != LAST_IDX) begin
            idx <= idx + DCW'(1);
         end

         if (start)                                   upd_pend <= 1'b0;
         else if (i_update_request && state != S_INIT) upd_pend <= 1'b1;
         o_update_start <= start;

         o_weight_valid <= fwd;
         if (fwd) begin
            o_rw_weight_select <= fwd_read;
            o_weight_layer     <= fwd_layer;
            o_weight_addr      <= fwd_addr;
            o_weight           <= fwd_data;
         end

         // a coincident arg-max strobe bypasses the latched value
         if (i_arg_max_valid) arg_q <= i_arg_max;
         o_action_valid <= i_main_net_done;
         if (i_main_net_done) o_action <= i_arg_max_valid ? i_arg_max : arg_q;

         o_busy <= (state_next != S_IDLE);
      end
   end

endmodule
